// File: rtl/sbqm_sensor_ctrl.sv
// Photocell front end for the bank queue manager: sync, debounce, edge-detect, buffer, and emit count/up_down pulses.
// Optional stuck-sensor detection is built when SBQM_SENSOR_STUCK_DET_EN is defined.
module sbqm_sensor_ctrl #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEB_CYCLES   = 4,
  parameter int PEND_W       = 2,
  parameter int STUCK_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       front_sensor,
  input  logic       back_sensor,
  output logic       count,
  output logic       up_down,
  output logic       busy,
  output logic       event_drop,
  output logic       sensor_fault,
  output logic [1:0] o_dbg_state
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, PULSE = 2'd2, HOLD = 2'd3} state_t;

  // Index 0 is the front (arrival) sensor, index 1 the back (departure) sensor.
  logic [SYNC_STAGES-1:0] r_sync [2];
  logic [DEB_W-1:0]       r_deb_cnt [2];
  logic [1:0]             r_deb;
  logic [1:0]             r_deb_q;
  logic [PEND_W-1:0]      r_arr_pend;
  logic [PEND_W-1:0]      r_dep_pend;
  logic                   r_count;
  logic                   r_up_down;
  logic                   r_drop;
  state_t                 r_state;

  logic [1:0] w_raw;
  logic [1:0] w_sync;
  logic       w_arr;
  logic       w_dep;
  logic       w_inc_a;
  logic       w_inc_d;
  logic       w_deq_a;
  logic       w_deq_d;
  state_t     w_next;

  assign w_raw  = {back_sensor, front_sensor};
  assign w_sync = {r_sync[1][SYNC_STAGES-1], r_sync[0][SYNC_STAGES-1]};
  assign w_arr  = r_deb[0] & ~r_deb_q[0];
  assign w_dep  = r_deb[1] & ~r_deb_q[1];
  // Simultaneous arrival and departure net to zero before reaching the buffers.
  assign w_inc_a = w_arr & ~w_dep;
  assign w_inc_d = w_dep & ~w_arr;

  function automatic logic [PEND_W-1:0] pend_next(input logic [PEND_W-1:0] v,
                                                  input logic inc, input logic deq);
    if (inc && !deq) return (v == PEND_MAX) ? v : v + PEND_W'(1);
    if (deq && !inc) return v - PEND_W'(1);
    return v;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        r_sync[i]    <= '0;
        r_deb_cnt[i] <= '0;
      end
      r_deb   <= '0;
      r_deb_q <= '0;
    end else begin
      r_deb_q <= r_deb;
      for (int i = 0; i < 2; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_raw[i]};
        if (w_sync[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_LAST) begin
          r_deb[i]     <= w_sync[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    w_deq_a = 1'b0;
    w_deq_d = 1'b0;
    case (r_state)
      IDLE: begin
        // Matched pairs cancel here so the occupancy counter never sees them.
        if (r_arr_pend != '0 && r_dep_pend != '0) begin
          w_deq_a = 1'b1;
          w_deq_d = 1'b1;
        end else if (r_arr_pend != '0) begin
          w_deq_a = 1'b1;
          w_next  = SETUP;
        end else if (r_dep_pend != '0) begin
          w_deq_d = 1'b1;
          w_next  = SETUP;
        end
      end
      SETUP:   w_next = PULSE;
      PULSE:   w_next = HOLD;
      HOLD:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_arr_pend <= '0;
      r_dep_pend <= '0;
      r_count    <= 1'b0;
      r_up_down  <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_arr_pend <= pend_next(r_arr_pend, w_inc_a, w_deq_a);
      r_dep_pend <= pend_next(r_dep_pend, w_inc_d, w_deq_d);
      r_count    <= (w_next == PULSE);
      r_drop     <= (w_inc_a & ~w_deq_a & (r_arr_pend == PEND_MAX)) |
                    (w_inc_d & ~w_deq_d & (r_dep_pend == PEND_MAX));
      if (r_state == IDLE && w_next == SETUP) r_up_down <= w_deq_a;
    end
  end

  assign count       = r_count;
  assign up_down     = r_up_down;
  assign busy        = (r_state != IDLE);
  assign event_drop  = r_drop;
  assign o_dbg_state = r_state;

`ifdef SBQM_SENSOR_STUCK_DET_EN
  localparam int STK_W = $clog2(STUCK_CYCLES + 1);
  localparam logic [STK_W-1:0] STK_MAX = STK_W'(STUCK_CYCLES);

  logic [STK_W-1:0] r_stk [2];
  logic             r_fault;

  // Counts cycles a debounced level has stayed high; the fault flag is sticky.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stk[0] <= '0;
      r_stk[1] <= '0;
      r_fault  <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!r_deb[i])              r_stk[i] <= '0;
        else if (r_stk[i] != STK_MAX) r_stk[i] <= r_stk[i] + STK_W'(1);
        if (r_stk[i] == STK_MAX) r_fault <= 1'b1;
      end
    end
  end

  assign sensor_fault = r_fault;
`else
  assign sensor_fault = 1'b0;
`endif

endmodule

// File: tb/tb_sbqm_sensor_ctrl.sv
// Directed bench for sbqm_sensor_ctrl: a default-parameter instance plus a DEB_CYCLES=1 instance
// that can generate events faster than the pulse service rate.
module tb_sbqm_sensor_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       front, back, f_front, f_back;
  logic       count, up_down, busy, event_drop, sensor_fault;
  logic       f_count, f_up_down, f_busy, f_event_drop, f_sensor_fault;
  logic [1:0] dbg_state, f_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Running totals from the monitors; tests compare differences across a window.
  int n_pulse = 0, n_up = 0, n_down = 0, n_high = 0, n_busy = 0, n_drop = 0, n_bad = 0;
  int f_pulse = 0, f_up = 0, f_down = 0, f_drop = 0, f_bad = 0;
  logic p_count = 1'b0, p_ud = 1'b0, fp_count = 1'b0, fp_ud = 1'b0;

  int s_pulse, s_up, s_down, s_high, s_busy, s_drop, s_bad;
  int sf_pulse, sf_up, sf_down, sf_drop, sf_bad;
  int lat;
  logic exp_fault;

  always #5 clk = ~clk;

  sbqm_sensor_ctrl #(.STUCK_CYCLES(64)) u_dut (
    .clk(clk), .reset_n(reset_n), .front_sensor(front), .back_sensor(back),
    .count(count), .up_down(up_down), .busy(busy), .event_drop(event_drop),
    .sensor_fault(sensor_fault), .o_dbg_state(dbg_state)
  );

  sbqm_sensor_ctrl #(.DEB_CYCLES(1)) u_fast (
    .clk(clk), .reset_n(reset_n), .front_sensor(f_front), .back_sensor(f_back),
    .count(f_count), .up_down(f_up_down), .busy(f_busy), .event_drop(f_event_drop),
    .sensor_fault(f_sensor_fault), .o_dbg_state(f_dbg_state)
  );

  // up_down must not move in the cycle of, before, or after a count high level.
  always @(negedge clk) begin
    if (!reset_n) begin
      p_count = 1'b0; p_ud = 1'b0; fp_count = 1'b0; fp_ud = 1'b0;
    end else begin
      if (count && !p_count) begin
        n_pulse++;
        if (up_down) n_up++; else n_down++;
        if (up_down !== p_ud) n_bad++;
      end
      if (count) n_high++;
      if (busy) n_busy++;
      if (event_drop) n_drop++;
      if (up_down !== p_ud && (count || p_count)) n_bad++;
      p_count = count; p_ud = up_down;
      if (f_count && !fp_count) begin
        f_pulse++;
        if (f_up_down) f_up++; else f_down++;
        if (f_up_down !== fp_ud) f_bad++;
      end
      if (f_event_drop) f_drop++;
      if (f_up_down !== fp_ud && (f_count || fp_count)) f_bad++;
      fp_count = f_count; fp_ud = f_up_down;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    s_pulse = n_pulse; s_up = n_up; s_down = n_down; s_high = n_high;
    s_busy = n_busy; s_drop = n_drop; s_bad = n_bad;
    sf_pulse = f_pulse; sf_up = f_up; sf_down = f_down; sf_drop = f_drop; sf_bad = f_bad;
  endtask

  task automatic wait_count(output int cycles);
    cycles = 0;
    while (count !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    front = 1'b0; back = 1'b0; f_front = 1'b0; f_back = 1'b0;
    wait_clks(3);
    check_eq("rst_count", count, 0);
    check_eq("rst_up_down", up_down, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_drop", event_drop, 0);
    check_eq("rst_fault", sensor_fault, 0);
    check_eq("rst_state", dbg_state, 0);
    reset_n = 1'b1;
    wait_clks(5);

    // Single arrival: 2 sync + 4 debounce + detect + dequeue + setup = count high 9 cycles after the raw rise.
    snap();
    front = 1'b1;
    wait_count(lat);
    check_eq("arr_latency", lat, 9);
    check_eq("arr_ud_in_pulse", up_down, 1);
    check_eq("arr_busy_in_pulse", busy, 1);
    wait_clks(1);
    check_eq("arr_count_fall", count, 0);
    check_eq("arr_ud_after", up_down, 1);
    wait_clks(20);
    front = 1'b0;
    wait_clks(20);
    check_eq("arr_pulses", n_pulse - s_pulse, 1);
    check_eq("arr_up", n_up - s_up, 1);
    check_eq("arr_width", n_high - s_high, 1);
    check_eq("arr_busy_cycles", n_busy - s_busy, 3);
    check_eq("arr_ud_stable", n_bad - s_bad, 0);

    // Glitch of DEB_CYCLES-1 is rejected; exactly DEB_CYCLES is accepted.
    snap();
    front = 1'b1; wait_clks(3); front = 1'b0;
    wait_clks(20);
    check_eq("glitch3_pulses", n_pulse - s_pulse, 0);
    check_eq("glitch3_pend", u_dut.r_arr_pend, 0);
    check_eq("glitch3_deb", u_dut.r_deb[0], 0);
    front = 1'b1; wait_clks(4); front = 1'b0;
    wait_clks(25);
    check_eq("glitch4_pulses", n_pulse - s_pulse, 1);
    check_eq("glitch4_up", n_up - s_up, 1);

    // Arrival and departure in the same cycle cancel.
    snap();
    front = 1'b1; back = 1'b1;
    wait_clks(20);
    check_eq("both_arr_pend", u_dut.r_arr_pend, 0);
    check_eq("both_dep_pend", u_dut.r_dep_pend, 0);
    front = 1'b0; back = 1'b0;
    wait_clks(20);
    check_eq("both_pulses", n_pulse - s_pulse, 0);

    // Fast instance: A, then D and A in separate cycles while busy -> pair cancels in IDLE.
    snap();
    f_front = 1'b1; wait_clks(1);
    f_front = 1'b0; wait_clks(1);
    f_back = 1'b1;  wait_clks(1);
    f_back = 1'b0; f_front = 1'b1; wait_clks(1);
    f_front = 1'b0;
    wait_clks(20);
    check_eq("pair_pulses", f_pulse - sf_pulse, 1);
    check_eq("pair_up", f_up - sf_up, 1);
    check_eq("pair_arr_pend", u_fast.r_arr_pend, 0);
    check_eq("pair_dep_pend", u_fast.r_dep_pend, 0);
    check_eq("pair_drop", f_drop - sf_drop, 0);
    snap();
    f_back = 1'b1; wait_clks(1); f_back = 1'b0;
    wait_clks(20);
    check_eq("dep_pulses", f_pulse - sf_pulse, 1);
    check_eq("dep_down", f_down - sf_down, 1);

    // Ten arrivals every 2 cycles against a 4-cycle service: two land on a full counter.
    snap();
    for (int i = 0; i < 10; i++) begin
      f_front = 1'b1; wait_clks(1);
      f_front = 1'b0; wait_clks(1);
    end
    wait_clks(60);
    check_eq("sat_pulses", f_pulse - sf_pulse, 8);
    check_eq("sat_up", f_up - sf_up, 8);
    check_eq("sat_drops", f_drop - sf_drop, 2);
    check_eq("sat_pend_drained", u_fast.r_arr_pend, 0);
    check_eq("fast_ud_stable", f_bad, 0);

    // Back held high long enough to trip the stuck detector when it is built.
`ifdef SBQM_SENSOR_STUCK_DET_EN
    exp_fault = 1'b1;
`else
    exp_fault = 1'b0;
`endif
    snap();
    back = 1'b1;
    wait_clks(110);
    check_eq("stuck_fault", sensor_fault, exp_fault);
    back = 1'b0;
    wait_clks(20);
    check_eq("stuck_sticky", sensor_fault, exp_fault);
    check_eq("stuck_down", n_down - s_down, 1);

    // Reset asserted while count is high drops it at once and loses the event.
    snap();
    front = 1'b1;
    wait_count(lat);
    check_eq("rstmid_seen_pulse", count, 1);
    #2;
    reset_n = 1'b0; front = 1'b0;
    #1;
    check_eq("rstmid_count", count, 0);
    check_eq("rstmid_busy", busy, 0);
    check_eq("rstmid_state", dbg_state, 0);
    check_eq("rstmid_fault", sensor_fault, 0);
    wait_clks(3);
    reset_n = 1'b1;
    wait_clks(30);
    check_eq("rstmid_pulses", n_pulse - s_pulse, 1);
    check_eq("rstmid_pend", u_dut.r_arr_pend, 0);
    check_eq("rstmid_ud", up_down, 0);
    check_eq("rstmid_drops", n_drop - s_drop, 0);
    check_eq("main_ud_stable", n_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
